// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CODE_W  = 5;

    localparam logic [ADDR_W-1:0] RESET_PC_DFLT = 32'hbfc00000;
    localparam logic [CODE_W-1:0] EXC_ADEL_DFLT = 5'd4;
    localparam logic [CODE_W-1:0] EXC_TLBL_DFLT = 5'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    // Slot handed to decode.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic              cancelled;
        logic              exc;
        logic              exc_miss;
        logic [CODE_W-1:0] exccode;
    } fetch_slot_t;

    // Word fetches must be 4-byte aligned.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// SRAM-like instruction request channel: one outstanding request at most.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction bus and
// presents the slot consumed by decode. Branch targets apply after the delay
// slot is accepted; exception redirects apply immediately.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DFLT,
    parameter logic [CODE_W-1:0] EXC_ADEL = EXC_ADEL_DFLT,
    parameter logic [CODE_W-1:0] EXC_TLBL = EXC_TLBL_DFLT
) (
    input  logic                 clk,
    input  logic                 resetn,
    fetch_stage_if.master        bus,
    input  logic                 itlb_miss,
    input  logic                 itlb_invalid,
    input  logic                 de_advance,
    input  logic                 br_valid,
    input  logic [ADDR_W-1:0]    br_target,
    input  logic                 exc_redirect,
    input  logic [ADDR_W-1:0]    exc_target,
    output logic                 valid_o,
    output logic [ADDR_W-1:0]    pc_o,
    output logic                 cancelled_o,
    output logic                 exc_o,
    output logic                 exc_miss_o,
    output logic [CODE_W-1:0]    exccode_o,
    output logic [ADDR_W-1:0]    perfcnt_redirect
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              br_pending_q, br_pending_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic [ADDR_W-1:0] perf_q, perf_d;
    fetch_slot_t       slot_q, slot_d;

    logic slot_free;
    logic misaligned;
    logic fexc;
    logic addr_acc;

    // Next-state, PC, branch-pending and slot update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        br_pending_d = br_pending_q;
        br_tgt_d     = br_tgt_q;
        perf_d       = perf_q;
        slot_d       = slot_q;

        slot_free  = !slot_q.valid || de_advance;
        misaligned = is_misaligned(pc_q);
        fexc       = misaligned || itlb_miss || itlb_invalid;
        addr_acc   = (state_q == S_REQ) && bus.inst_addr_ok;

        // Decode took the slot; a load below may refill it in the same cycle.
        if (de_advance) begin
            slot_d.valid     = 1'b0;
            slot_d.cancelled = 1'b0;
        end

        if (exc_redirect) begin
            pc_d            = exc_target;
            br_pending_d    = 1'b0;
            perf_d          = perf_q + 32'd1;
            slot_d.exc      = 1'b0;
            slot_d.exc_miss = 1'b0;
            slot_d.exccode  = '0;
            if (((state_q == S_WAIT) && !bus.inst_data_ok) || addr_acc) begin
                // A response is still owed; keep a squashed slot until it drains.
                slot_d.valid     = 1'b1;
                slot_d.cancelled = 1'b1;
                if (addr_acc) begin
                    slot_d.pc = pc_q;
                end
                state_d = S_WAIT;
            end else begin
                slot_d.valid     = 1'b0;
                slot_d.cancelled = 1'b0;
                state_d          = S_IDLE;
            end
        end else begin
            // Taken branch not consumed by an accept this cycle waits for the next one.
            if (br_valid && !addr_acc) begin
                br_pending_d = 1'b1;
                br_tgt_d     = br_target;
            end
            case (state_q)
                S_IDLE: begin
                    if (slot_free) begin
                        if (fexc) begin
                            slot_d.valid     = 1'b1;
                            slot_d.pc        = pc_q;
                            slot_d.cancelled = 1'b0;
                            slot_d.exc       = 1'b1;
                            slot_d.exc_miss  = itlb_miss && !misaligned;
                            slot_d.exccode   = misaligned ? EXC_ADEL : EXC_TLBL;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.inst_addr_ok) begin
                        slot_d.valid     = 1'b1;
                        slot_d.pc        = pc_q;
                        slot_d.cancelled = 1'b0;
                        slot_d.exc       = 1'b0;
                        slot_d.exc_miss  = 1'b0;
                        slot_d.exccode   = '0;
                        if (br_valid) begin
                            pc_d   = br_target;
                            perf_d = perf_q + 32'd1;
                        end else if (br_pending_q) begin
                            pc_d   = br_tgt_q;
                            perf_d = perf_q + 32'd1;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                        br_pending_d = 1'b0;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.inst_data_ok) begin
                        state_d = (slot_free && !fexc) ? S_REQ : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            br_pending_q <= 1'b0;
            br_tgt_q     <= '0;
            perf_q       <= '0;
            slot_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            br_pending_q <= br_pending_d;
            br_tgt_q     <= br_tgt_d;
            perf_q       <= perf_d;
            slot_q       <= slot_d;
        end
    end

    assign bus.inst_req  = (state_q == S_REQ);
    assign bus.inst_addr = pc_q;

    assign valid_o          = slot_q.valid;
    assign pc_o             = slot_q.pc;
    assign cancelled_o      = slot_q.cancelled;
    assign exc_o            = slot_q.exc;
    assign exc_miss_o       = slot_q.exc_miss;
    assign exccode_o        = slot_q.exccode;
    assign perfcnt_redirect = perf_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, delayed branch, exception
// redirect with orphan response, fetch exceptions and asynchronous reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic              clk;
    logic              resetn;
    logic              itlb_miss;
    logic              itlb_invalid;
    logic              de_advance;
    logic              br_valid;
    logic [31:0]       br_target;
    logic              exc_redirect;
    logic [31:0]       exc_target;
    logic              valid_o;
    logic [31:0]       pc_o;
    logic              cancelled_o;
    logic              exc_o;
    logic              exc_miss_o;
    logic [4:0]        exccode_o;
    logic [31:0]       perfcnt_redirect;

    int total = 0;
    int bad   = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus              (bus),
        .itlb_miss        (itlb_miss),
        .itlb_invalid     (itlb_invalid),
        .de_advance       (de_advance),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .exc_redirect     (exc_redirect),
        .exc_target       (exc_target),
        .valid_o          (valid_o),
        .pc_o             (pc_o),
        .cancelled_o      (cancelled_o),
        .exc_o            (exc_o),
        .exc_miss_o       (exc_miss_o),
        .exccode_o        (exccode_o),
        .perfcnt_redirect (perfcnt_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upper bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn           = 1'b0;
        itlb_miss        = 1'b0;
        itlb_invalid     = 1'b0;
        de_advance       = 1'b0;
        br_valid         = 1'b0;
        br_target        = '0;
        exc_redirect     = 1'b0;
        exc_target       = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;

        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc_o",  pc_o, 32'h0);
        chk("rst_addr",  bus.inst_addr, 32'hbfc00000);
        chk("rst_req",   32'(bus.inst_req), 32'd0);
        chk("rst_perf",  perfcnt_redirect, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Sequential fetch: bfc00000, bfc00004, bfc00008.
        step();
        chk("seq0_req",  32'(bus.inst_req), 32'd1);
        chk("seq0_addr", bus.inst_addr, 32'hbfc00000);
        bus.inst_addr_ok = 1'b1;
        step();
        chk("seq0_valid", 32'(valid_o), 32'd1);
        chk("seq0_pc_o",  pc_o, 32'hbfc00000);
        chk("seq0_canc",  32'(cancelled_o), 32'd0);
        chk("seq0_wait_req", 32'(bus.inst_req), 32'd0);
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; de_advance = 1'b1;
        step();
        chk("seq1_req",  32'(bus.inst_req), 32'd1);
        chk("seq1_addr", bus.inst_addr, 32'hbfc00004);
        chk("seq1_slot_clear", 32'(valid_o), 32'd0);
        bus.inst_data_ok = 1'b0; de_advance = 1'b0; bus.inst_addr_ok = 1'b1;
        step();
        chk("seq1_pc_o", pc_o, 32'hbfc00004);
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; de_advance = 1'b1;
        step();
        chk("seq2_addr", bus.inst_addr, 32'hbfc00008);
        bus.inst_data_ok = 1'b0; de_advance = 1'b0;

        // Branch resolved while delay slot bfc00008 waits 3 cycles for addr_ok.
        br_valid = 1'b1; br_target = 32'hbfc00100;
        step();
        br_valid = 1'b0;
        chk("br_hold_addr", bus.inst_addr, 32'hbfc00008);
        chk("br_hold_req",  32'(bus.inst_req), 32'd1);
        step();
        step();
        chk("br_perf_pending", perfcnt_redirect, 32'd0);
        bus.inst_addr_ok = 1'b1;
        step();
        chk("br_delay_pc_o", pc_o, 32'hbfc00008);
        chk("br_next_addr",  bus.inst_addr, 32'hbfc00100);
        chk("br_perf",       perfcnt_redirect, 32'd1);
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; de_advance = 1'b1;
        step();
        chk("br_tgt_req", 32'(bus.inst_req), 32'd1);
        bus.inst_data_ok = 1'b0; de_advance = 1'b0;

        // Branch coinciding with addr_ok applies to that same advance.
        bus.inst_addr_ok = 1'b1; br_valid = 1'b1; br_target = 32'hbfc00200;
        step();
        br_valid = 1'b0; bus.inst_addr_ok = 1'b0;
        chk("brsame_pc_o", pc_o, 32'hbfc00100);
        chk("brsame_addr", bus.inst_addr, 32'hbfc00200);
        chk("brsame_perf", perfcnt_redirect, 32'd2);

        // Exception redirect during WAIT leaves an orphan response.
        exc_redirect = 1'b1; exc_target = 32'hbfc00380;
        step();
        exc_redirect = 1'b0;
        chk("exc_canc",  32'(cancelled_o), 32'd1);
        chk("exc_valid", 32'(valid_o), 32'd1);
        chk("exc_addr",  bus.inst_addr, 32'hbfc00380);
        chk("exc_perf",  perfcnt_redirect, 32'd3);
        chk("exc_noreq", 32'(bus.inst_req), 32'd0);
        step();
        chk("orphan_noreq", 32'(bus.inst_req), 32'd0);
        chk("orphan_canc",  32'(cancelled_o), 32'd1);
        bus.inst_data_ok = 1'b1; de_advance = 1'b1;
        step();
        bus.inst_data_ok = 1'b0; de_advance = 1'b0;
        chk("drain_canc", 32'(cancelled_o), 32'd0);
        chk("drain_req",  32'(bus.inst_req), 32'd1);
        chk("drain_addr", bus.inst_addr, 32'hbfc00380);

        // Redirect to a misaligned target: ADEL slot, no request.
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0;
        exc_redirect = 1'b1; exc_target = 32'hbfc00382;
        step();
        exc_redirect = 1'b0;
        bus.inst_data_ok = 1'b1; de_advance = 1'b1;
        step();
        bus.inst_data_ok = 1'b0; de_advance = 1'b0;
        chk("adel_noreq0", 32'(bus.inst_req), 32'd0);
        step();
        chk("adel_valid", 32'(valid_o), 32'd1);
        chk("adel_exc",   32'(exc_o), 32'd1);
        chk("adel_code",  32'(exccode_o), 32'd4);
        chk("adel_miss",  32'(exc_miss_o), 32'd0);
        chk("adel_pc_o",  pc_o, 32'hbfc00382);
        step();
        chk("adel_noreq1", 32'(bus.inst_req), 32'd0);

        // ITLB miss at 0x00400000.
        exc_redirect = 1'b1; exc_target = 32'h00400000; itlb_miss = 1'b1;
        step();
        exc_redirect = 1'b0;
        chk("tlbl_flush_valid", 32'(valid_o), 32'd0);
        chk("tlbl_flush_perf",  perfcnt_redirect, 32'd5);
        step();
        chk("tlbl_exc",   32'(exc_o), 32'd1);
        chk("tlbl_code",  32'(exccode_o), 32'd2);
        chk("tlbl_miss",  32'(exc_miss_o), 32'd1);
        chk("tlbl_pc_o",  pc_o, 32'h00400000);
        chk("tlbl_noreq", 32'(bus.inst_req), 32'd0);

        // ITLB invalid: TLBL without the refill flag.
        exc_redirect = 1'b1; exc_target = 32'h00400000;
        itlb_miss = 1'b0; itlb_invalid = 1'b1;
        step();
        exc_redirect = 1'b0;
        step();
        chk("tlbi_code", 32'(exccode_o), 32'd2);
        chk("tlbi_miss", 32'(exc_miss_o), 32'd0);
        itlb_invalid = 1'b0;

        // Reset while a request is in WAIT.
        exc_redirect = 1'b1; exc_target = 32'hbfc00010;
        step();
        exc_redirect = 1'b0;
        step();
        chk("pre_rst_req", 32'(bus.inst_req), 32'd1);
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0;
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        chk("pre_rst_perf",  perfcnt_redirect, 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_pc_o",  pc_o, 32'h0);
        chk("arst_perf",  perfcnt_redirect, 32'd0);
        chk("arst_addr",  bus.inst_addr, 32'hbfc00000);
        chk("arst_req",   32'(bus.inst_req), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("post_rst_req",  32'(bus.inst_req), 32'd1);
        chk("post_rst_addr", bus.inst_addr, 32'hbfc00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
